// File: rtl/gera_codigo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gera_codigo_pkg
// Description : Shared types and constants for the gera_codigo code
//               transmitter: FSM state encoding, symbol width and result
//               encoding used by system benches.
// Revision    : 1.0 - initial release
// ============================================================================
package gera_codigo_pkg;

    // Width of one transmitted symbol ({e1,e0})
    localparam int SYM_W = 2;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STROBE    = 3'd1,
        GAP       = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Result encoding for benches that pack {ok,fail,timeout} into a code
    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_OK      = 2'd1;
    localparam logic [1:0] RES_FAIL    = 2'd2;
    localparam logic [1:0] RES_TIMEOUT = 2'd3;

endpackage : gera_codigo_pkg
`default_nettype wire

// File: rtl/gera_codigo.sv
`default_nettype none
// ============================================================================
// Module      : gera_codigo
// Description : Code transmitter for the e0/e1/e2 keypad-style protocol.
//               On an accepted start it latches N_SYM 2-bit symbols, sends
//               each on {e1,e0} with a one-cycle e2 strobe separated by
//               GAP_CYCLES idle cycles, then waits up to TIMEOUT cycles for
//               the detector verdict (s1 = accepted, s2 = rejected).
// Ports       : clk, rst_n (async, active-low)
//               start, code_in[2*N_SYM-1:0]  - transaction request / code
//               s1, s2                       - detector verdict
//               e0, e1, e2                   - symbol bits and strobe
//               busy, done                   - transaction status
//               ok, fail, timeout            - held result flags
// Revision    : 1.0 - initial release
// ============================================================================
module gera_codigo
    import gera_codigo_pkg::*;
#(
    parameter int N_SYM      = 2,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SYM_W*N_SYM-1:0] code_in,
    input  logic                   s1,
    input  logic                   s2,
    output logic                   e0,
    output logic                   e1,
    output logic                   e2,
    output logic                   busy,
    output logic                   done,
    output logic                   ok,
    output logic                   fail,
    output logic                   timeout
);

    localparam int CODE_W = SYM_W * N_SYM;
    localparam int IDX_W  = $clog2(N_SYM + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int WIN_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_SYM - 1);
    localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WIN_W-1:0] c_WIN_LAST = WIN_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_shift;
    logic [IDX_W-1:0]  r_idx;
    logic [GAP_W-1:0]  r_gap;
    logic [WIN_W-1:0]  r_win;

    logic              w_last_sym;
    logic              w_gap_end;
    logic              w_win_end;

    logic              r_e0, r_e1, r_e2, r_busy, r_done, r_ok, r_fail, r_timeout;
    logic [SYM_W-1:0]  w_sym_nxt;
    logic              w_e2_nxt, w_busy_nxt, w_done_nxt;
    logic              w_ok_nxt, w_fail_nxt, w_timeout_nxt;

    // The latched code is consumed from the bottom: symbol 0 sits in the low
    // bits and each completed gap shifts the next symbol down.
    assign w_code_shift = r_code >> SYM_W;
    assign w_last_sym   = (r_idx == c_IDX_LAST);
    assign w_gap_end    = (r_gap == c_GAP_LAST);
    assign w_win_end    = (r_win == c_WIN_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (start) w_state_nxt = STROBE;
            STROBE:    w_state_nxt = w_last_sym ? WAIT_RESP : GAP;
            GAP:       if (w_gap_end) w_state_nxt = STROBE;
            WAIT_RESP: if (s1 || s2 || w_win_end) w_state_nxt = DONE;
            DONE:      w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values for the output registers, derived from the
    // state being entered so outputs line up with the new state.
    // ------------------------------------------------------------------
    always_comb begin
        w_sym_nxt     = {r_e1, r_e0};
        w_ok_nxt      = r_ok;
        w_fail_nxt    = r_fail;
        w_timeout_nxt = r_timeout;
        case (r_state)
            IDLE: begin
                if (start) begin
                    // code is latched on this same edge, so take symbol 0 from the input
                    w_sym_nxt     = code_in[SYM_W-1:0];
                    w_ok_nxt      = 1'b0;
                    w_fail_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                end
            end
            GAP: begin
                if (w_gap_end) w_sym_nxt = w_code_shift[SYM_W-1:0];
            end
            WAIT_RESP: begin
                // s2 has priority when both verdicts arrive together
                if (s2) begin
                    w_fail_nxt = 1'b1;
                end else if (s1) begin
                    w_ok_nxt = 1'b1;
                end else if (w_win_end) begin
                    w_timeout_nxt = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_state_nxt == DONE) w_sym_nxt = '0;
        w_e2_nxt   = (w_state_nxt == STROBE);
        w_busy_nxt = (w_state_nxt == STROBE) || (w_state_nxt == GAP) ||
                     (w_state_nxt == WAIT_RESP);
        w_done_nxt = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0      <= 1'b0;
            r_e1      <= 1'b0;
            r_e2      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ok      <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_e0      <= w_sym_nxt[0];
            r_e1      <= w_sym_nxt[1];
            r_e2      <= w_e2_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ok      <= w_ok_nxt;
            r_fail    <= w_fail_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Code latch and counters. Gap and window counters are held at zero
    // outside their own state, so they always start from 0 on entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= '0;
            r_idx  <= '0;
            r_gap  <= '0;
            r_win  <= '0;
        end else begin
            r_gap <= '0;
            r_win <= '0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_code <= code_in;
                        r_idx  <= '0;
                    end
                end
                GAP: begin
                    if (w_gap_end) begin
                        r_idx  <= r_idx + IDX_W'(1);
                        r_code <= w_code_shift;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                WAIT_RESP: begin
                    if (!w_win_end) r_win <= r_win + WIN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign e0      = r_e0;
    assign e1      = r_e1;
    assign e2      = r_e2;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ok      = r_ok;
    assign fail    = r_fail;
    assign timeout = r_timeout;

endmodule : gera_codigo
`default_nettype wire

// File: tb/tb_gera_codigo.sv
`default_nettype none
// ============================================================================
// Module      : tb_gera_codigo
// Description : Directed self-checking bench for gera_codigo (N_SYM=2,
//               GAP_CYCLES=1, TIMEOUT=16). Cycle c is the clock period that
//               ends at rising edge c; start is sampled at edge 0.
//               Observed word per cycle: {e2,e1,e0,busy,done,ok,fail,timeout}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gera_codigo;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] code_in;
    logic       s1;
    logic       s2;
    logic       e0, e1, e2, busy, done, ok, fail, timeout;

    int         nchk;
    int         nerr;
    logic [7:0] obs [0:31];

    gera_codigo #(
        .N_SYM      (2),
        .GAP_CYCLES (1),
        .TIMEOUT    (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .code_in (code_in),
        .s1      (s1),
        .s2      (s2),
        .e0      (e0),
        .e1      (e1),
        .e2      (e2),
        .busy    (busy),
        .done    (done),
        .ok      (ok),
        .fail    (fail),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one transaction: start high before edge 0, then for each cycle
    // record the outputs mid-cycle and set inputs to be sampled at its end.
    task automatic run_txn(input logic [3:0] code, input logic hold,
                           input logic [31:0] st_mask, input logic [31:0] s1_mask,
                           input logic [31:0] s2_mask, input int ncyc);
        @(negedge clk);
        code_in = code;
        start   = 1'b1;
        s1      = 1'b0;
        s2      = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            obs[c] = {e2, e1, e0, busy, done, ok, fail, timeout};
            start  = (hold && (c < ncyc)) || st_mask[c];
            s1     = s1_mask[c];
            s2     = s2_mask[c];
        end
        start = 1'b0;
        s1    = 1'b0;
        s2    = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] o;
        rst_n   = 1'b0;
        start   = 1'b1;
        code_in = 4'b1110;
        s1      = 1'b0;
        s2      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            o = {e2, e1, e0, busy, done, ok, fail, timeout};
            nchk++;
            if (o !== 8'h00) begin
                nerr++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, o, 8'h00);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        o = {e2, e1, e0, busy, done, ok, fail, timeout};
        nchk++;
        if (o !== 8'b1101_0000) begin
            nerr++;
            $display("FAIL reset_first_strobe: got %b expected %b", o, 8'b1101_0000);
        end
        start = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic test_correct_code;
        int         cy [6] = '{1, 2, 3, 4, 5, 6};
        logic [7:0] ex [6] = '{8'b1101_0000, 8'b0101_0000, 8'b1111_0000,
                               8'b0111_0000, 8'b0000_1100, 8'b0000_0100};
        run_txn(4'b1110, 1'b0, 32'h0, 32'h1 << 4, 32'h0, 6);
        for (int i = 0; i < 6; i++) begin
            nchk++;
            if (obs[cy[i]] !== ex[i]) begin
                nerr++;
                $display("FAIL correct_code c%0d: got %b expected %b", cy[i], obs[cy[i]], ex[i]);
            end
        end
    endtask

    task automatic test_wrong_code;
        int         cy [5] = '{1, 2, 3, 4, 5};
        logic [7:0] ex [5] = '{8'b1111_0000, 8'b0111_0000, 8'b1111_0000,
                               8'b0111_0000, 8'b0000_1010};
        run_txn(4'b1111, 1'b0, 32'h0, 32'h0, 32'h1 << 4, 6);
        for (int i = 0; i < 5; i++) begin
            nchk++;
            if (obs[cy[i]] !== ex[i]) begin
                nerr++;
                $display("FAIL wrong_code c%0d: got %b expected %b", cy[i], obs[cy[i]], ex[i]);
            end
        end
    endtask

    task automatic test_silence;
        int         cy [5] = '{4, 12, 19, 20, 21};
        logic [7:0] ex [5] = '{8'b0111_0000, 8'b0111_0000, 8'b0111_0000,
                               8'b0000_1001, 8'b0000_0001};
        run_txn(4'b1110, 1'b0, 32'h0, 32'h0, 32'h0, 21);
        for (int i = 0; i < 5; i++) begin
            nchk++;
            if (obs[cy[i]] !== ex[i]) begin
                nerr++;
                $display("FAIL silence c%0d: got %b expected %b", cy[i], obs[cy[i]], ex[i]);
            end
        end
    endtask

    task automatic test_conflicts;
        int         cy [6] = '{1, 2, 3, 4, 5, 6};
        logic [7:0] ex [6] = '{8'b1101_0000, 8'b0101_0000, 8'b1111_0000,
                               8'b0111_0000, 8'b0000_1010, 8'b0000_0010};
        // start and s1 both raised during the gap, then s1+s2 together
        run_txn(4'b1110, 1'b0, 32'h1 << 2, (32'h1 << 2) | (32'h1 << 4), 32'h1 << 4, 6);
        for (int i = 0; i < 6; i++) begin
            nchk++;
            if (obs[cy[i]] !== ex[i]) begin
                nerr++;
                $display("FAIL conflicts c%0d: got %b expected %b", cy[i], obs[cy[i]], ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int         cy [7] = '{4, 5, 6, 7, 10, 11, 12};
        logic [7:0] ex [7] = '{8'b0111_0000, 8'b0000_1100, 8'b0000_0100,
                               8'b1101_0000, 8'b0111_0000, 8'b0000_1010,
                               8'b0000_0010};
        run_txn(4'b1110, 1'b1, 32'h0, 32'h1 << 4, 32'h1 << 10, 12);
        for (int i = 0; i < 7; i++) begin
            nchk++;
            if (obs[cy[i]] !== ex[i]) begin
                nerr++;
                $display("FAIL back_to_back c%0d: got %b expected %b", cy[i], obs[cy[i]], ex[i]);
            end
        end
    endtask

    task automatic test_midop_reset;
        logic [7:0] o;
        int         cy [3] = '{1, 3, 5};
        logic [7:0] ex [3] = '{8'b1101_0000, 8'b1011_0000, 8'b0000_1100};
        @(negedge clk);
        code_in = 4'b1111;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        o = {e2, e1, e0, busy, done, ok, fail, timeout};
        nchk++;
        if (o !== 8'b1111_0000) begin
            nerr++;
            $display("FAIL midop_pre_strobe: got %b expected %b", o, 8'b1111_0000);
        end
        @(negedge clk);
        o = {e2, e1, e0, busy, done, ok, fail, timeout};
        nchk++;
        if (o !== 8'b0111_0000) begin
            nerr++;
            $display("FAIL midop_pre_gap: got %b expected %b", o, 8'b0111_0000);
        end
        rst_n = 1'b0;
        #1;
        o = {e2, e1, e0, busy, done, ok, fail, timeout};
        nchk++;
        if (o !== 8'h00) begin
            nerr++;
            $display("FAIL midop_async_reset: got %b expected %b", o, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(4'b0110, 1'b0, 32'h0, 32'h1 << 4, 32'h0, 5);
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (obs[cy[i]] !== ex[i]) begin
                nerr++;
                $display("FAIL midop_resend c%0d: got %b expected %b", cy[i], obs[cy[i]], ex[i]);
            end
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        test_reset();
        test_correct_code();
        test_wrong_code();
        test_silence();
        test_conflicts();
        test_back_to_back();
        test_midop_reset();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule : tb_gera_codigo
`default_nettype wire

// File: doc/gera_codigo.md
Name: gera_codigo

Overview:
Code transmitter, the driving end of the e0/e1/e2 keypad-style protocol consumed by the detecta code detector. On a start request it latches an N-symbol code. Each 2-bit symbol goes out on e1/e0 with a one-cycle e2 strobe, separated by idle gaps. It then waits for the detector's verdict (s1 = code accepted, s2 = code rejected) and reports ok, fail or timeout. It is used as a stimulus/master block in front of detecta and as a self-checking source in system benches.

Parameters:
N_SYM, 2, number of 2-bit symbols per code (>=1)
GAP_CYCLES, 1, cycles with e2=0 between consecutive strobes (>=1)
TIMEOUT, 16, max response-window cycles to wait for s1/s2 (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request to send; sampled only in IDLE
code_in  in  2*N_SYM  code; symbol i = code_in[2i+1:2i], symbol 0 sent first; latched on accepted start
s1  in  1  detector "code correct" indication
s2  in  1  detector "code wrong" indication
e0  out  1  symbol bit 0 (registered)
e1  out  1  symbol bit 1 (registered)
e2  out  1  symbol strobe, one-cycle pulse per symbol (registered)
busy  out  1  high from the cycle after accepted start until the done pulse
done  out  1  one-cycle pulse when the transaction ends
ok  out  1  result: s1 seen; held until next accepted start
fail  out  1  result: s2 seen; held until next accepted start
timeout  out  1  result: no response within TIMEOUT; held until next accepted start

Behaviour:
- Reset (async, any time, including mid-transaction): state=IDLE; e0=e1=e2=0; busy=done=ok=fail=timeout=0; all counters 0; latched code cleared.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, STROBE, GAP, WAIT_RESP, DONE.
- IDLE: start=1 at edge k latches code_in, clears ok/fail/timeout, and sets symbol index=0. Next state STROBE. Start is ignored in every other state.
- STROBE (exactly 1 cycle): e1/e0 = current symbol bits [1]/[0], e2=1, busy=1.
  - If the symbol is not the last one: go to GAP.
  - If it is the last one: go to WAIT_RESP.
- GAP (exactly GAP_CYCLES cycles): e1/e0 held at the symbol just strobed, e2=0. Then increment the index and go to STROBE with the next symbol.
- Timing: strobe of symbol i occurs in cycle k+1+i*(1+GAP_CYCLES).
- WAIT_RESP: e1/e0 held, e2=0, window counter counts from 0. s1/s2 are sampled every WAIT_RESP cycle.
  - s2=1 -> fail=1.
  - s1=1 and s2=0 -> ok=1.
  - Both high in the same cycle -> fail wins.
  - Counter reaches TIMEOUT with neither seen -> timeout=1.
  - In every case the result flag is set on the same edge that enters DONE.
- s1/s2 outside WAIT_RESP are ignored, including any early assertion during STROBE/GAP.
- DONE (1 cycle): done=1, busy=0, e0=e1=0. Next state IDLE. The result flags keep their value.
- Exactly one of ok/fail/timeout is 1 after any completed transaction.
- Counter widths: index uses $clog2(N_SYM+1); gap counter uses $clog2(GAP_CYCLES+1); window counter uses $clog2(TIMEOUT+1). Counters never wrap: each is compared against its terminal value and cleared on state entry.
- A start held high continuously causes back-to-back transactions, each beginning from the IDLE cycle after DONE.

Decomposition:
- Package gera_codigo_pkg:
  - state enum (IDLE, STROBE, GAP, WAIT_RESP, DONE)
  - localparam SYM_W=2
  - result encoding constants for bench use
- No sub-module. A single FSM plus three counters is the natural size (~150 lines).

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 -> all outputs 0, no strobe. Release -> first strobe one cycle after start is sampled.
- Correct code: code_in=4'b11_10, GAP=1, start at edge 0 -> {e1,e0}=10 with e2=1 in cycle 1; 10 held with e2=0 in cycle 2; 11 with e2=1 in cycle 3. Responder raises s1 in cycle 4 -> done=1 and ok=1 in cycle 5, busy low in cycle 5.
- Wrong code: code_in=4'b11_11, responder raises s2 in cycle 4 -> fail=1, ok=0, done pulse in cycle 5.
- Silence: no s1/s2 -> WAIT_RESP occupies cycles 4..19; timeout=1 with done in cycle 20.
- Conflicts: start pulsed in cycle 2 is ignored (sequence unchanged). s1 in cycle 2 is ignored. s1 and s2 together in cycle 4 -> fail=1, ok=0.
- Mid-op reset: rst_n=0 during cycle 2 -> e2=0 and busy=0 immediately. A new start resends from symbol 0 with the newly latched code_in.
